// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32 M-extension types, divide sequencer states and zero-divisor constants
package rv32i_types;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } mex_funct3_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } mdu_seq_state_t;

    localparam logic [31:0] MDU_DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_reuse_buf.sv
// mdu_reuse_buf: last divider result cache and hit compare, present only with MDU_DIVREM_REUSE_EN
`ifdef MDU_DIVREM_REUSE_EN
module mdu_reuse_buf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        upd_i,
    input  logic        inv_i,
    input  logic [31:0] upd_rs1_i,
    input  logic [31:0] upd_rs2_i,
    input  logic        upd_sgn_i,
    input  logic [31:0] upd_quot_i,
    input  logic [31:0] upd_rem_i,
    input  logic [31:0] lk_rs1_i,
    input  logic [31:0] lk_rs2_i,
    input  logic        lk_sgn_i,
    input  logic        lk_rem_i,
    output logic        hit_o,
    output logic [31:0] data_o
);
    logic        valid_q, sgn_q;
    logic [31:0] rs1_q, rs2_q, quot_q, rem_q;

    // Drop the entry when a divide is abandoned, otherwise refill on each completed divide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            sgn_q   <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else if (inv_i) begin
            valid_q <= 1'b0;
        end else if (upd_i) begin
            valid_q <= 1'b1;
            sgn_q   <= upd_sgn_i;
            rs1_q   <= upd_rs1_i;
            rs2_q   <= upd_rs2_i;
            quot_q  <= upd_quot_i;
            rem_q   <= upd_rem_i;
        end
    end

    assign hit_o  = valid_q & (rs1_q == lk_rs1_i) & (rs2_q == lk_rs2_i) & (sgn_q == lk_sgn_i);
    assign data_o = lk_rem_i ? rem_q : quot_q;

endmodule
`endif

// File: rtl/mdu_div_sequencer.sv
// mdu_div_sequencer: EX-side divide request sequencer driving the divider; MDU_DIVREM_REUSE_EN adds a result cache
module mdu_div_sequencer
    import rv32i_types::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  mex_funct3_t req_funct3_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    output logic        req_ready_o,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        div_start_o,
    output mex_funct3_t div_op_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    input  logic        div_fin_i,
    input  logic [31:0] div_quotient_i,
    input  logic [31:0] div_remainder_i
);
    mdu_seq_state_t state_q, state_d;
    mex_funct3_t    op_q;
    logic [31:0]    rs1_q, rs2_q, res_q, res_d, fast_data, hit_data;
    logic           accept, fast, hit, div_done;

    assign accept    = req_valid_i & req_ready_o & ~flush_i;
    assign div_done  = (state_q == WAIT) & div_fin_i & ~flush_i;
    assign fast      = (req_rs2_i == '0) | ~req_funct3_i[2] | hit;
    assign fast_data = ~req_funct3_i[2]    ? '0 :
                       (req_rs2_i == '0)   ? (req_funct3_i[1] ? req_rs1_i : MDU_DIV0_QUOT) :
                                             hit_data;

`ifdef MDU_DIVREM_REUSE_EN
    mdu_reuse_buf u_reuse (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .upd_i      (div_done),
        .inv_i      (flush_i & ((state_q == ISSUE) | (state_q == WAIT))),
        .upd_rs1_i  (rs1_q),
        .upd_rs2_i  (rs2_q),
        .upd_sgn_i  (op_q[0]),
        .upd_quot_i (div_quotient_i),
        .upd_rem_i  (div_remainder_i),
        .lk_rs1_i   (req_rs1_i),
        .lk_rs2_i   (req_rs2_i),
        .lk_sgn_i   (req_funct3_i[0]),
        .lk_rem_i   (req_funct3_i[1]),
        .hit_o      (hit),
        .data_o     (hit_data)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // Next state; a flush that coincides with fin in WAIT has nothing left to drain
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (fast ? RESP : ISSUE) : IDLE;
            ISSUE:   state_d = flush_i ? DRAIN : WAIT;
            WAIT:    state_d = flush_i ? (div_fin_i ? IDLE : DRAIN) : (div_fin_i ? RESP : WAIT);
            RESP:    state_d = IDLE;
            DRAIN:   state_d = div_fin_i ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // Result register: fast-path value on accept, selected divider field on fin
    always_comb begin
        res_d = (accept & fast) ? fast_data :
                div_done        ? (op_q[1] ? div_remainder_i : div_quotient_i) :
                                  res_q;
    end

    // State and request latches; operands stay put until the next accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= divu;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            if (accept) begin
                op_q  <= req_funct3_i;
                rs1_q <= req_rs1_i;
                rs2_q <= req_rs2_i;
            end
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign stall_o        = ~req_ready_o;
    assign resp_valid_o   = (state_q == RESP) & ~flush_i;
    assign resp_data_o    = res_q;
    assign div_start_o    = (state_q == ISSUE);
    assign div_op_o       = op_q;
    assign div_dividend_o = rs1_q;
    assign div_divisor_o  = rs2_q;

endmodule

// File: tb/tb_mdu_div_sequencer.sv
// tb_mdu_div_sequencer: scoreboard bench with a behavioural divider and reference model
module tb_mdu_div_sequencer;
    import rv32i_types::*;

`ifdef MDU_DIVREM_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          divp;
        int          acc;
        int          starts;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, flush = 1'b0, spur = 1'b0;
    mex_funct3_t req_funct3 = divu;
    logic [31:0] req_rs1 = '0, req_rs2 = '0;
    logic        req_ready, stall, resp_valid, div_start, div_fin;
    logic [31:0] resp_data, div_dividend, div_divisor, div_quotient, div_remainder;
    mex_funct3_t div_op;

    int          checks = 0, errors = 0, ncyc = 0, starts = 0, exp_starts = 0;
    bit          fin_prev = 1'b0;
    exp_t        q[$];
    exp_t        mon_e;
    mex_funct3_t cur_f = divu;
    logic [31:0] cur_a = '0, cur_b = '0, last_a = '0, last_b = '0;
    bit          c_valid = 1'b0, c_sgn = 1'b0;
    logic [31:0] c_a = '0, c_b = '0;

    int          cnt = 0, lat = 34;
    mex_funct3_t d_op = divu;
    logic [31:0] d_a = '0, d_b = 32'd1;

    mdu_div_sequencer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_funct3_i    (req_funct3),
        .req_rs1_i       (req_rs1),
        .req_rs2_i       (req_rs2),
        .req_ready_o     (req_ready),
        .flush_i         (flush),
        .stall_o         (stall),
        .resp_valid_o    (resp_valid),
        .resp_data_o     (resp_data),
        .div_start_o     (div_start),
        .div_op_o        (div_op),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_fin_i       (div_fin),
        .div_quotient_i  (div_quotient),
        .div_remainder_i (div_remainder)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input mex_funct3_t f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 32'h0;
        if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
            return f[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end
        return f[1] ? a % b : a / b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (div_start) begin
            cnt  <= lat;
            d_op <= div_op;
            d_a  <= div_dividend;
            d_b  <= div_divisor;
        end else if (cnt != 0) cnt <= cnt - 1;
    end

    assign div_fin       = (cnt == 1) | spur;
    assign div_quotient  = ref_res(mex_funct3_t'({2'b10, d_op[0]}), d_a, d_b);
    assign div_remainder = ref_res(mex_funct3_t'({2'b11, d_op[0]}), d_a, d_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (div_start) begin
            starts++;
            chk("start_op", div_op, cur_f);
            chk("start_a", div_dividend, cur_a);
            chk("start_b", div_divisor, cur_b);
        end
        if (cnt == 1) begin
            chk("fin_stall", stall, 1);
            chk("fin_a_stable", div_dividend, d_a);
            chk("fin_b_stable", div_divisor, d_b);
        end
        if (resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp got %h expected none", resp_data);
            end else begin
                mon_e = q.pop_front();
                chk("resp_data", resp_data, mon_e.data);
                chk("resp_stall", stall, 1);
                chk("start_count", starts, mon_e.starts);
                if (mon_e.divp) chk("fin_to_resp", fin_prev, 1);
                else chk("fast_latency", ncyc, mon_e.acc + 1);
            end
        end
        fin_prev = div_fin;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got 0 expected 1");
        end
    endtask

    task automatic drive(input mex_funct3_t f, input logic [31:0] a, input logic [31:0] b);
        cur_f = f;
        cur_a = a;
        cur_b = b;
        req_funct3 = f;
        req_rs1 = a;
        req_rs2 = b;
        req_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic bookkeep(input mex_funct3_t f, input logic [31:0] a, input logic [31:0] b, output bit divp);
        bit hit;
        hit  = REUSE && c_valid && c_a == a && c_b == b && c_sgn == f[0];
        divp = f[2] && b != 32'h0 && !hit;
        if (divp) begin
            exp_starts++;
            c_valid = 1'b1;
            c_a = a;
            c_b = b;
            c_sgn = f[0];
        end
    endtask

    task automatic do_req(input mex_funct3_t f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] x, input bit use_x);
        exp_t e;
        wait_ready();
        drive(f, a, b);
        bookkeep(f, a, b, e.divp);
        e.data   = use_x ? x : ref_res(f, a, b);
        e.acc    = ncyc;
        e.starts = exp_starts;
        q.push_back(e);
        last_a = a;
        last_b = b;
        #1 req_valid = 1'b0;
    endtask

    task automatic flush_req();
        bit divp;
        int n = 0;
        lat = 20;
        wait_ready();
        drive(divu, 32'hDEAD_BEEF, 32'h1357);
        bookkeep(divu, 32'hDEAD_BEEF, 32'h1357, divp);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        c_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!div_fin && n < 100);
        chk("drain_fin_seen", div_fin, 1);
        chk("drain_busy", req_ready, 0);
        @(negedge clk);
        chk("drain_ready", req_ready, 1);
        chk("drain_stall", stall, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_start", div_start, 0);
        chk("rst_op", div_op, divu);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        rst_n = 1'b1;

        do_req(divu, 32'd100, 32'd7, 32'd14, 1);
        do_req(div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
        do_req(rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
        do_req(remu, 32'h1234, 32'd0, 32'h1234, 1);
        do_req(div, 32'h55, 32'd0, 32'hFFFF_FFFF, 1);
        do_req(div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_req(rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        do_req(mul, 32'd5, 32'd3, 32'h0, 1);
        do_req(div, 32'd50, 32'd6, 32'd8, 1);
        do_req(rem, 32'd50, 32'd6, 32'd2, 1);
        do_req(remu, 32'd50, 32'd6, 32'd2, 1);

        flush_req();
        lat = 34;
        do_req(divu, 32'd1000, 32'd9, 32'd111, 1);

        wait_ready();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_ready", req_ready, 1);
        chk("spur_valid", resp_valid, 0);

        begin
            bit divp;
            wait_ready();
            drive(div, 32'h7777, 32'd13);
            bookkeep(div, 32'h7777, 32'd13, divp);
            #1 req_valid = 1'b0;
            repeat (6) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("arst_ready", req_ready, 1);
            chk("arst_stall", stall, 0);
            chk("arst_start", div_start, 0);
            chk("arst_op", div_op, divu);
            chk("arst_dividend", div_dividend, 0);
            chk("arst_data", resp_data, 0);
            c_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        do_req(remu, 32'd1000, 32'd9, 32'd1, 1);

        for (int i = 0; i < 60; i++) begin
            mex_funct3_t f;
            logic [31:0] a, b;
            int r;
            f = mex_funct3_t'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            a = $urandom();
            b = (r < 5) ? $urandom_range(1, 300) : $urandom();
            if (r == 0) b = 32'h0;
            if (r == 1) begin
                a = last_a;
                b = last_b;
            end
            if (r == 2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (r == 3) a = 32'h0 - $urandom_range(1, 1000);
            lat = $urandom_range(2, 40);
            do_req(f, a, b, 32'h0, 0);
        end

        repeat (60) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
